// File: rtl/conv_stream_bridge.sv
// conv_stream_bridge: packs a 16-bit word stream into the convolution engine's flattened
// buses, starts it, then streams the flattened result back out. Watchdog: CONV_BRIDGE_TIMEOUT_EN.
module conv_stream_bridge #(
   parameter  int LEN             = 3,
   parameter  int SIGNAL_LENGTH_1 = 15,
   parameter  int TIMEOUT         = 4096,
   localparam int N_OUT           = LEN + SIGNAL_LENGTH_1 + 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic signed [15:0]              s_data,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic signed [15:0]              m_data,
   output logic                            m_last,
   output logic                            load,
   output logic [(LEN+1)*16:0]             flaten_filter_coeff,
   output logic [(SIGNAL_LENGTH_1+1)*16:0] flaten_signal,
   input  logic [N_OUT*16:0]               flatten_conv_result,
   input  logic                            is_completed,
   output logic                            busy,
   output logic                            err
);

   localparam int MAXC = (LEN > SIGNAL_LENGTH_1) ? LEN : SIGNAL_LENGTH_1;
   localparam int IW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
   localparam int KW   = $clog2(N_OUT + 1);

   typedef enum logic [2:0] {S_COEF, S_SIG, S_LOAD, S_WAIT, S_DRAIN} state_t;

   typedef struct packed {
      logic signed [15:0] data;
      logic               last;
   } beat_t;

   state_t                          state;
   logic [IW-1:0]                   idx;
   logic [KW-1:0]                   k;
   logic                            done_q;
   logic                            load_q;
   logic                            mv_q;
   logic [LEN:0][15:0]              coef_q;
   logic [SIGNAL_LENGTH_1:0][15:0]  sig_q;
   logic                            accept;
   logic                            coef_wr;
   logic                            sig_wr;
   logic                            out_hs;
   logic                            done_edge;
   beat_t                           beat;
   logic                            unused_msb;

   // Outputs are forced quiet for the whole time rst is asserted, not just after the edge.
   assign s_ready   = ~rst & ((state == S_COEF) || (state == S_SIG));
   assign busy      = ~rst & ((state == S_LOAD) || (state == S_WAIT) || (state == S_DRAIN));
   assign load      = ~rst & load_q;
   assign m_valid   = ~rst & mv_q;
   assign m_data    = beat.data;
   assign m_last    = m_valid & beat.last;

   assign accept    = s_valid & s_ready;
   assign coef_wr   = accept & (state == S_COEF);
   assign sig_wr    = accept & (state == S_SIG);
   assign out_hs    = m_valid & m_ready;
   assign done_edge = is_completed & ~done_q;

   assign flaten_filter_coeff = {1'b0, coef_q};
   assign flaten_signal       = {1'b0, sig_q};
   assign unused_msb          = flatten_conv_result[N_OUT*16];

   // Result words are muxed straight off the engine bus; the engine holds it during DRAIN.
   always_comb begin
      beat      = '0;
      beat.last = (k == KW'(N_OUT - 1));
      for (int i = 0; i < N_OUT; i++)
         if (k == KW'(i)) beat.data = flatten_conv_result[i*16 +: 16];
   end

   // Slot storage is never reset: a dropped job leaves the last words on the buses.
   always_ff @(posedge clk) begin
      for (int i = 0; i <= LEN; i++)
         if (coef_wr && idx == IW'(i)) coef_q[i] <= s_data;
      for (int i = 0; i <= SIGNAL_LENGTH_1; i++)
         if (sig_wr && idx == IW'(i)) sig_q[i] <= s_data;
   end

`ifdef CONV_BRIDGE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] wcnt;
   logic          err_q;
   assign err = ~rst & err_q;
`else
   localparam int unused_timeout = TIMEOUT;
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_COEF;
         idx    <= '0;
         k      <= '0;
         done_q <= 1'b0;
         load_q <= 1'b0;
         mv_q   <= 1'b0;
`ifdef CONV_BRIDGE_TIMEOUT_EN
         wcnt   <= '0;
         err_q  <= 1'b0;
`endif
      end else begin
         // done_q follows the engine in every state so a held-over level never looks like an edge.
         done_q <= is_completed;
         load_q <= 1'b0;
`ifdef CONV_BRIDGE_TIMEOUT_EN
         err_q  <= 1'b0;
`endif
         case (state)
            S_COEF: begin
               if (accept) begin
                  if (idx == IW'(LEN)) begin
                     idx   <= '0;
                     state <= S_SIG;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            S_SIG: begin
               if (accept) begin
                  if (idx == IW'(SIGNAL_LENGTH_1)) begin
                     idx    <= '0;
                     load_q <= 1'b1;
                     state  <= S_LOAD;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            S_LOAD: begin
               state <= S_WAIT;
`ifdef CONV_BRIDGE_TIMEOUT_EN
               wcnt  <= '0;
`endif
            end
            S_WAIT: begin
               if (done_edge) begin
                  k     <= '0;
                  mv_q  <= 1'b1;
                  state <= S_DRAIN;
               end
`ifdef CONV_BRIDGE_TIMEOUT_EN
               else if (wcnt == TW'(TIMEOUT - 1)) begin
                  err_q <= 1'b1;
                  idx   <= '0;
                  state <= S_COEF;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
`endif
            end
            S_DRAIN: begin
               if (out_hs) begin
                  if (beat.last) begin
                     mv_q  <= 1'b0;
                     k     <= '0;
                     idx   <= '0;
                     state <= S_COEF;
                  end else begin
                     k <= k + 1'b1;
                  end
               end
            end
            default: state <= S_COEF;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_stream_bridge.sv
// Scoreboard bench for conv_stream_bridge: a behavioural engine convolves whatever sits on the
// DUT buses, and expected results come from a reference convolution of the words sent.
module tb_conv_stream_bridge;

   localparam int LEN = 3;
   localparam int SL1 = 15;
   localparam int NO  = LEN + SL1 + 1;
`ifdef CONV_BRIDGE_TIMEOUT_EN
   localparam int TMO = 50;
`else
   localparam int TMO = 4096;
`endif

   typedef int coef_a [LEN+1];
   typedef int sig_a  [SL1+1];
   typedef struct {
      logic [15:0] d;
      logic        l;
   } beat_t;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                s_valid = 1'b0;
   logic signed [15:0]  s_data = '0;
   logic                m_ready = 1'b0;
   logic                is_completed = 1'b0;
   logic [NO*16:0]      fr = '0;
   logic                s_ready, m_valid, m_last, load, busy, err;
   logic signed [15:0]  m_data;
   logic [(LEN+1)*16:0] fc;
   logic [(SL1+1)*16:0] fs;

   conv_stream_bridge #(.LEN(LEN), .SIGNAL_LENGTH_1(SL1), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .load(load), .flaten_filter_coeff(fc), .flaten_signal(fs),
      .flatten_conv_result(fr), .is_completed(is_completed),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int    total = 0;
   int    bad = 0;
   int    cyc = 0;
   int    comp_cyc = -100;
   int    sready_cyc = -1;
   int    popped = 0;
   int    eng_hold = 0;
   int    eng_lat = 4;
   bit    eng_never = 1'b0;
   bit    mr_rand = 1'b0;
   bit    prev_mv = 1'b0;
   beat_t exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   // Full linear convolution, Q14 scaled, truncated to 16 bits.
   function automatic logic [15:0] conv_at(input coef_a h, input sig_a x, input int n);
      longint acc = 0;
      for (int j = 0; j <= LEN; j++)
         if (n - j >= 0 && n - j <= SL1) acc += longint'(h[j]) * longint'(x[n-j]);
      acc = acc >>> 14;
      return 16'(acc);
   endfunction

   // Engine: drops done on load (optionally late), computes from the DUT buses, raises done.
   initial begin
      coef_a eh;
      sig_a  ex;
      forever begin
         @(negedge clk);
         if (load) begin
            repeat (eng_hold + 1) @(posedge clk);
            #1 is_completed = 1'b0;
            if (!eng_never) begin
               repeat (eng_lat) @(posedge clk);
               #1;
               for (int j = 0; j <= LEN; j++) eh[j] = $signed(fc[j*16 +: 16]);
               for (int i = 0; i <= SL1; i++) ex[i] = $signed(fs[i*16 +: 16]);
               for (int n = 0; n < NO; n++) fr[n*16 +: 16] = conv_at(eh, ex, n);
               fr[NO*16]    = 1'b1;
               is_completed = 1'b1;
               comp_cyc     = cyc;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1 m_ready = mr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: every valid cycle is compared with the queue head; pop only on handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (cyc == sready_cyc) chk("s_ready_after_last", {m_valid, s_ready}, 2'b01);
         if (m_valid && !prev_mv) chk("drain_start_cycle", cyc, comp_cyc + 1);
         prev_mv = m_valid;
         if (m_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", exp_q.size(), 1);
            end else begin
               chk("m_data_last", {m_last, m_data}, {exp_q[0].l, exp_q[0].d});
               if (m_ready) begin
                  if (exp_q[0].l) sready_cyc = cyc + 1;
                  void'(exp_q.pop_front());
                  popped++;
               end
            end
         end
      end
   end

   task automatic send(input logic [15:0] d, input int gap);
      bit acc;
      int c;
      if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
         s_valid = 1'b0;
         s_data  = 16'($urandom);
         @(posedge clk);
         #1;
      end
      s_valid = 1'b1;
      s_data  = d;
      acc = 1'b0;
      c = 0;
      while (!acc && c < 100) begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk);
         #1;
         c++;
      end
      chk("word_accepted", acc, 1);
   endtask

   task automatic run_job(input coef_a h, input sig_a x, input int gap, input int abort_at,
                          input bit to_job);
      int lc;
      int c;
      popped = 0;
      if (!to_job)
         for (int n = 0; n < NO; n++) begin
            beat_t b;
            b.d = conv_at(h, x, n);
            b.l = (n == NO - 1);
            exp_q.push_back(b);
         end
      for (int i = 0; i <= LEN; i++) send(16'(h[i]), gap);
      for (int i = 0; i <= SL1; i++) send(16'(x[i]), gap);
      s_valid = 1'b0;
      @(negedge clk);
      chk("load_pulse", {load, busy, s_ready}, 3'b110);
      lc = cyc;
      @(negedge clk);
      chk("load_width", {load, busy}, 2'b01);
      if (to_job) begin
         c = 0;
         while (!err && c < 200) begin
            @(negedge clk);
            c++;
         end
         chk("err_cycle", cyc, lc + TMO + 1);
         @(negedge clk);
         chk("err_once", {err, s_ready, busy}, 3'b010);
      end else if (abort_at >= 0) begin
         c = 0;
         while (popped < abort_at && c < 1000) begin
            @(posedge clk);
            #2;
            c++;
         end
         chk("abort_point", popped, abort_at);
         rst = 1'b1;
         exp_q.delete();
         @(negedge clk);
         chk("rst_mid_drain", {m_valid, s_ready}, 2'b00);
         @(posedge clk);
         #1 rst = 1'b0;
         @(negedge clk);
         chk("after_abort", {m_valid, s_ready, busy}, 3'b010);
      end else begin
         c = 0;
         while (exp_q.size() != 0 && c < 1000) begin
            @(posedge clk);
            #2;
            c++;
         end
         chk("drain_done", exp_q.size(), 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      coef_a h;
      sig_a  x;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {s_ready, load, m_valid, m_last, err, busy}, 6'b000000);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("release_outputs", {s_ready, load, m_valid, m_last, err, busy}, 6'b100000);
      @(posedge clk);
      #1;

      for (int i = 0; i <= SL1; i++) x[i] = i + 1;
      h = '{16384, 0, 0, 0};
      run_job(h, x, 0, -1, 1'b0);
      h = '{0, 16384, 0, 0};
      run_job(h, x, 0, -1, 1'b0);

      mr_rand = 1'b1;
      h = '{16384, 0, 0, 0};
      run_job(h, x, 1, -1, 1'b0);
      mr_rand = 1'b0;

      eng_hold = 3;
      for (int j = 0; j <= LEN; j++) h[j] = $signed(16'($urandom));
      for (int i = 0; i <= SL1; i++) x[i] = $signed(16'($urandom));
      run_job(h, x, 0, -1, 1'b0);
      eng_hold = 0;

      for (int i = 0; i <= SL1; i++) x[i] = $signed(16'($urandom));
      run_job(h, x, 0, 5, 1'b0);
      for (int j = 0; j <= LEN; j++) h[j] = $signed(16'($urandom));
      run_job(h, x, 0, -1, 1'b0);

      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j <= LEN; j++) h[j] = $signed(16'($urandom));
         for (int i = 0; i <= SL1; i++) x[i] = $signed(16'($urandom));
         mr_rand = 1'b1;
         run_job(h, x, 2, -1, 1'b0);
      end
      mr_rand = 1'b0;

`ifdef CONV_BRIDGE_TIMEOUT_EN
      eng_never = 1'b1;
      run_job(h, x, 0, -1, 1'b1);
      eng_never = 1'b0;
      for (int i = 0; i <= SL1; i++) x[i] = i + 1;
      run_job(h, x, 0, -1, 1'b0);
`endif

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
